// File: rtl/sdram_arbiter_rr_if.sv
// Bundle of the client-side and controller-side handshake signals around the arbiter.
interface sdram_arbiter_rr_if #(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16
);
  localparam int unsigned MASK_W = DATA_W / 8;

  // controller side
  logic                          sdram_cmd_valid;
  logic                          sdram_cmd_ready;
  logic                          sdram_rd;
  logic                          sdram_wr;
  logic [ADDR_W-1:0]             sdram_addr_x16;
  logic [DATA_W-1:0]             sdram_wdata;
  logic [MASK_W-1:0]             sdram_wmask;
  logic                          sdram_burst;
  logic                          sdram_ack;
  logic                          sdram_rdy;
  logic                          sdram_resp_valid;
  logic [DATA_W-1:0]             sdram_rdata;

  // client side
  logic [NUM_CLIENTS-1:0]        cli_cmd_valid;
  logic [NUM_CLIENTS-1:0]        cli_cmd_ready;
  logic [NUM_CLIENTS-1:0]        cli_rd;
  logic [NUM_CLIENTS-1:0]        cli_wr;
  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr_x16;
  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata;
  logic [NUM_CLIENTS*MASK_W-1:0] cli_wmask;
  logic [NUM_CLIENTS-1:0]        cli_ack;
  logic [NUM_CLIENTS-1:0]        cli_rdy;
  logic [NUM_CLIENTS-1:0]        cli_resp_valid;
  logic [DATA_W-1:0]             cli_rdata;

  // status
  logic [2:0]                    grant_idx;
  logic                          busy;

  modport master (
    output sdram_cmd_valid, sdram_rd, sdram_wr, sdram_addr_x16, sdram_wdata,
           sdram_wmask, sdram_burst, sdram_ack,
           cli_cmd_ready, cli_rdy, cli_resp_valid, cli_rdata, grant_idx, busy,
    input  sdram_cmd_ready, sdram_rdy, sdram_resp_valid, sdram_rdata,
           cli_cmd_valid, cli_rd, cli_wr, cli_addr_x16, cli_wdata, cli_wmask, cli_ack
  );

  modport slave (
    input  sdram_cmd_valid, sdram_rd, sdram_wr, sdram_addr_x16, sdram_wdata,
           sdram_wmask, sdram_burst, sdram_ack,
           cli_cmd_ready, cli_rdy, cli_resp_valid, cli_rdata, grant_idx, busy,
    output sdram_cmd_ready, sdram_rdy, sdram_resp_valid, sdram_rdata,
           cli_cmd_valid, cli_rd, cli_wr, cli_addr_x16, cli_wdata, cli_wmask, cli_ack
  );
endinterface

// File: rtl/sdram_arbiter_rr.sv
// N-client arbiter in front of the single-command SDRAM controller.
// One client is granted per transaction and keeps the grant until it acks.
module sdram_arbiter_rr #(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned PRIO_MODE   = 0,
  parameter logic [7:0]  BURST_MASK  = 8'b001
) (
  input logic                clk_i,
  input logic                rst_i,
  sdram_arbiter_rr_if.master bus
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned OFF_W  = IDX_W + 1;
  localparam int unsigned WCNT_W = 3;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WCNT_W-1:0]      wait_q, wait_d;

  logic                   any_valid;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       search_base;
  logic [OFF_W-1:0]       off, best_off;
  logic [IDX_W-1:0]       sel_idx;
  logic                   drive_cmd;

  logic                   cmd_valid_c, rd_c, wr_c, burst_c, ack_c;
  logic [ADDR_W-1:0]      addr_c;
  logic [DATA_W-1:0]      wdata_c;
  logic [MASK_W-1:0]      wmask_c;
  logic [NUM_CLIENTS-1:0] cmd_ready_c, rdy_c, resp_valid_c;

  // Winner search: smallest distance from the search base among valid clients
  always_comb begin
    any_valid   = |bus.cli_cmd_valid;
    search_base = (PRIO_MODE != 0) ? '0 : rr_ptr_q;
    win_idx     = '0;
    best_off    = '1;
    off         = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (IDX_W'(i) >= search_base)
        off = OFF_W'(i) - {1'b0, search_base};
      else
        off = OFF_W'(i) + OFF_W'(NUM_CLIENTS) - {1'b0, search_base};
      if (bus.cli_cmd_valid[i] && (off < best_off)) begin
        best_off = off;
        win_idx  = IDX_W'(i);
      end
    end
  end

  // State and grant registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wait_q   <= wait_d;
    end
  end

  // Next state, command forwarding and per-client response routing
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    wait_d       = (wait_q != '0) ? WCNT_W'(wait_q - 1'b1) : '0;
    cmd_valid_c  = 1'b0;
    rd_c         = 1'b0;
    wr_c         = 1'b0;
    burst_c      = 1'b0;
    ack_c        = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;
    wmask_c      = '0;
    cmd_ready_c  = '0;
    rdy_c        = '0;
    resp_valid_c = '0;

    sel_idx   = (state_q == ST_BUSY) ? grant_q : win_idx;
    drive_cmd = (state_q == ST_BUSY) || any_valid;

    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (drive_cmd && (sel_idx == IDX_W'(i))) begin
        rd_c    = bus.cli_rd[i];
        wr_c    = bus.cli_wr[i] & ~BURST_MASK[i];
        burst_c = BURST_MASK[i];
        addr_c  = bus.cli_addr_x16[i*ADDR_W +: ADDR_W];
        wdata_c = bus.cli_wdata[i*DATA_W +: DATA_W];
        wmask_c = bus.cli_wmask[i*MASK_W +: MASK_W];
      end
    end

    case (state_q)
      ST_IDLE: begin
        cmd_valid_c = any_valid;
        for (int i = 0; i < NUM_CLIENTS; i++)
          if (any_valid && (win_idx == IDX_W'(i))) cmd_ready_c[i] = bus.sdram_cmd_ready;
        if (any_valid && bus.sdram_cmd_ready) begin
          state_d = ST_BUSY;
          grant_d = win_idx;
          wait_d  = WCNT_W'(WAIT_CYCLES);
          if (PRIO_MODE == 0)
            rr_ptr_d = (win_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : IDX_W'(win_idx + 1'b1);
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          if (grant_q == IDX_W'(i)) begin
            ack_c           = bus.cli_ack[i];
            rdy_c[i]        = bus.sdram_rdy & (wait_q == '0);
            resp_valid_c[i] = bus.sdram_resp_valid;
          end
        end
        if (ack_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs stay quiet for as long as reset is held
    if (rst_i) begin
      cmd_valid_c  = 1'b0;
      rd_c         = 1'b0;
      wr_c         = 1'b0;
      ack_c        = 1'b0;
      cmd_ready_c  = '0;
      rdy_c        = '0;
      resp_valid_c = '0;
    end
  end

  assign bus.sdram_cmd_valid = cmd_valid_c;
  assign bus.sdram_rd        = rd_c;
  assign bus.sdram_wr        = wr_c;
  assign bus.sdram_addr_x16  = addr_c;
  assign bus.sdram_wdata     = wdata_c;
  assign bus.sdram_wmask     = wmask_c;
  assign bus.sdram_burst     = burst_c;
  assign bus.sdram_ack       = ack_c;
  assign bus.cli_cmd_ready   = cmd_ready_c;
  assign bus.cli_rdy         = rdy_c;
  assign bus.cli_resp_valid  = resp_valid_c;
  assign bus.cli_rdata       = bus.sdram_rdata;
  assign bus.grant_idx       = grant_q;
  assign bus.busy            = (state_q == ST_BUSY);
endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Bench for sdram_arbiter_rr: a round-robin instance and a fixed-priority instance.
module tb_sdram_arbiter_rr;
  logic clk_i;
  logic rst_i;

  sdram_arbiter_rr_if #(.NUM_CLIENTS(3), .ADDR_W(24), .DATA_W(16)) rr_if ();
  sdram_arbiter_rr_if #(.NUM_CLIENTS(3), .ADDR_W(24), .DATA_W(16)) fp_if ();

  sdram_arbiter_rr #(.NUM_CLIENTS(3), .ADDR_W(24), .DATA_W(16), .WAIT_CYCLES(2),
                     .PRIO_MODE(0), .BURST_MASK(8'b001))
    u_rr (.clk_i(clk_i), .rst_i(rst_i), .bus(rr_if));

  sdram_arbiter_rr #(.NUM_CLIENTS(3), .ADDR_W(24), .DATA_W(16), .WAIT_CYCLES(2),
                     .PRIO_MODE(1), .BURST_MASK(8'b001))
    u_fp (.clk_i(clk_i), .rst_i(rst_i), .bus(fp_if));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_ready;
    logic [2:0] exp_grant;
  } vec_t;

  localparam int NV = 11;
  vec_t        vecs[NV];
  logic [23:0] addr_tbl[3];
  int unsigned exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Steps until the chosen instance reports busy (bounded), then scores the grant
  task automatic wait_grant(input bit fp);
    int         n;
    logic       b;
    logic [2:0] g;
    n = 0;
    b = 1'b0;
    do begin
      @(posedge clk_i); #1;
      n++;
      b = fp ? fp_if.busy : rr_if.busy;
    end while (!b && n < 8);
    chk("busy_after_accept", 32'(b), 32'd1);
    g = fp ? fp_if.grant_idx : rr_if.grant_idx;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=%0d required=queued_grant", g);
    end else begin
      chk("grant_idx", 32'(g), exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b111, 3'b001, 3'd0};
    vecs[1]  = '{3'b111, 3'b010, 3'd1};
    vecs[2]  = '{3'b111, 3'b100, 3'd2};
    vecs[3]  = '{3'b111, 3'b001, 3'd0};
    vecs[4]  = '{3'b111, 3'b010, 3'd1};
    vecs[5]  = '{3'b111, 3'b100, 3'd2};
    vecs[6]  = '{3'b110, 3'b010, 3'd1};
    vecs[7]  = '{3'b011, 3'b001, 3'd0};
    vecs[8]  = '{3'b101, 3'b100, 3'd2};
    vecs[9]  = '{3'b100, 3'b100, 3'd2};
    vecs[10] = '{3'b010, 3'b010, 3'd1};
    addr_tbl[0] = 24'h100055;
    addr_tbl[1] = 24'h200055;
    addr_tbl[2] = 24'h300055;

    rst_i = 1'b1;
    rr_if.sdram_cmd_ready = 1'b1; rr_if.sdram_rdy = 1'b0; rr_if.sdram_resp_valid = 1'b0;
    rr_if.sdram_rdata = 16'h0;
    rr_if.cli_cmd_valid = 3'b111; rr_if.cli_rd = 3'b111; rr_if.cli_wr = 3'b000;
    rr_if.cli_addr_x16 = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};
    rr_if.cli_wdata = {16'h3333, 16'h2222, 16'h1111};
    rr_if.cli_wmask = 6'b111111; rr_if.cli_ack = 3'b000;
    fp_if.sdram_cmd_ready = 1'b1; fp_if.sdram_rdy = 1'b0; fp_if.sdram_resp_valid = 1'b0;
    fp_if.sdram_rdata = 16'h0;
    fp_if.cli_cmd_valid = 3'b000; fp_if.cli_rd = 3'b111; fp_if.cli_wr = 3'b000;
    fp_if.cli_addr_x16 = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};
    fp_if.cli_wdata = '0; fp_if.cli_wmask = '0; fp_if.cli_ack = 3'b000;

    // Reset state with requests already pending
    #3;
    chk("rst_cmd_valid", 32'(rr_if.sdram_cmd_valid), 32'd0);
    chk("rst_cmd_ready", 32'(rr_if.cli_cmd_ready), 32'd0);
    chk("rst_busy", 32'(rr_if.busy), 32'd0);
    chk("rst_grant", 32'(rr_if.grant_idx), 32'd0);
    chk("rst_rd", 32'(rr_if.sdram_rd), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    rr_if.cli_cmd_valid = 3'b000;
    @(posedge clk_i); #1;

    // Round-robin table: ack four cycles into each grant, one idle cycle between grants
    for (int v = 0; v < NV; v++) begin
      rr_if.cli_cmd_valid = vecs[v].valid;
      #1;
      chk("idle_busy", 32'(rr_if.busy), 32'd0);
      chk("idle_cmd_valid", 32'(rr_if.sdram_cmd_valid), 32'd1);
      chk("idle_cmd_ready", 32'(rr_if.cli_cmd_ready), 32'(vecs[v].exp_ready));
      chk("idle_addr", 32'(rr_if.sdram_addr_x16), 32'(addr_tbl[vecs[v].exp_grant]));
      exp_q.push_back(32'(vecs[v].exp_grant));
      wait_grant(1'b0);
      chk("busy_cmd_ready", 32'(rr_if.cli_cmd_ready), 32'd0);
      chk("busy_cmd_valid", 32'(rr_if.sdram_cmd_valid), 32'd0);
      repeat (3) begin @(posedge clk_i); #1; end
      rr_if.cli_ack = 3'(1 << vecs[v].exp_grant);
      #1;
      chk("ack_forward", 32'(rr_if.sdram_ack), 32'd1);
      @(posedge clk_i); #1;
      rr_if.cli_ack = 3'b000;
      chk("idle_gap", 32'(rr_if.busy), 32'd0);
    end

    // Client 1 write held through the transaction; rdy masked for two cycles
    rr_if.cli_rd = 3'b001; rr_if.cli_wr = 3'b010;
    rr_if.cli_addr_x16[47:24] = 24'h000123;
    rr_if.cli_wdata[31:16] = 16'hBEEF;
    rr_if.cli_wmask[3:2] = 2'b01;
    rr_if.sdram_rdy = 1'b1;
    rr_if.cli_cmd_valid = 3'b010;
    #1;
    chk("wr_accept_wr", 32'(rr_if.sdram_wr), 32'd1);
    chk("wr_accept_rd", 32'(rr_if.sdram_rd), 32'd0);
    chk("wr_accept_addr", 32'(rr_if.sdram_addr_x16), 32'h000123);
    chk("wr_accept_wdata", 32'(rr_if.sdram_wdata), 32'hBEEF);
    chk("wr_accept_wmask", 32'(rr_if.sdram_wmask), 32'h1);
    chk("wr_accept_burst", 32'(rr_if.sdram_burst), 32'd0);
    chk("wr_accept_rdy", 32'(rr_if.cli_rdy), 32'd0);
    exp_q.push_back(1);
    wait_grant(1'b0);
    rr_if.cli_cmd_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk_i); #1; end
      chk("wait_rdy", 32'(rr_if.cli_rdy), (c == 2) ? 32'h2 : 32'h0);
      chk("hold_addr", 32'(rr_if.sdram_addr_x16), 32'h000123);
      chk("hold_wdata", 32'(rr_if.sdram_wdata), 32'hBEEF);
      chk("hold_wr", 32'(rr_if.sdram_wr), 32'd1);
    end
    rr_if.cli_ack = 3'b010;
    @(posedge clk_i); #1;
    rr_if.cli_ack = 3'b000;
    rr_if.sdram_rdy = 1'b0;
    chk("wr_done_busy", 32'(rr_if.busy), 32'd0);

    // Burst client 0 busy; a stray ack from client 2 must be ignored
    rr_if.cli_rd = 3'b001; rr_if.cli_wr = 3'b001;
    rr_if.cli_cmd_valid = 3'b001;
    #1;
    chk("burst_flag", 32'(rr_if.sdram_burst), 32'd1);
    chk("burst_wr_forced", 32'(rr_if.sdram_wr), 32'd0);
    chk("burst_rd", 32'(rr_if.sdram_rd), 32'd1);
    exp_q.push_back(0);
    wait_grant(1'b0);
    rr_if.cli_cmd_valid = 3'b000;
    rr_if.cli_ack = 3'b100;
    rr_if.sdram_resp_valid = 1'b1;
    rr_if.sdram_rdata = 16'h1234;
    #1;
    chk("stray_ack", 32'(rr_if.sdram_ack), 32'd0);
    chk("resp_route", 32'(rr_if.cli_resp_valid), 32'h1);
    chk("rdata_bcast", 32'(rr_if.cli_rdata), 32'h1234);
    @(posedge clk_i); #1;
    rr_if.cli_ack = 3'b000;
    rr_if.sdram_resp_valid = 1'b0;
    chk("stray_busy", 32'(rr_if.busy), 32'd1);
    chk("stray_grant", 32'(rr_if.grant_idx), 32'd0);
    rr_if.cli_ack = 3'b001;
    @(posedge clk_i); #1;
    rr_if.cli_ack = 3'b000;
    chk("burst_done", 32'(rr_if.busy), 32'd0);

    // Fixed priority: client 0 keeps winning until it drops its request
    fp_if.cli_cmd_valid = 3'b101;
    for (int t = 0; t < 4; t++) begin
      if (t == 3) fp_if.cli_cmd_valid = 3'b100;
      #1;
      chk("fp_cmd_ready", 32'(fp_if.cli_cmd_ready), (t == 3) ? 32'h4 : 32'h1);
      exp_q.push_back((t == 3) ? 2 : 0);
      wait_grant(1'b1);
      chk("fp_wait_ready", 32'(fp_if.cli_cmd_ready), 32'd0);
      fp_if.cli_ack = (t == 3) ? 3'b100 : 3'b001;
      @(posedge clk_i); #1;
      fp_if.cli_ack = 3'b000;
      if (t == 3) fp_if.cli_cmd_valid = 3'b000;
      chk("fp_idle", 32'(fp_if.busy), 32'd0);
    end

    // Reset mid-transaction drops the grant at once; pointer restarts at 0
    rr_if.cli_rd = 3'b111; rr_if.cli_wr = 3'b000;
    rr_if.cli_cmd_valid = 3'b111;
    #1;
    exp_q.push_back(1);
    wait_grant(1'b0);
    rr_if.sdram_rdy = 1'b1;
    rr_if.sdram_resp_valid = 1'b1;
    #1;
    chk("pre_rst_resp", 32'(rr_if.cli_resp_valid), 32'h2);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(rr_if.busy), 32'd0);
    chk("rst_mid_grant", 32'(rr_if.grant_idx), 32'd0);
    chk("rst_mid_cmd_ready", 32'(rr_if.cli_cmd_ready), 32'd0);
    chk("rst_mid_rdy", 32'(rr_if.cli_rdy), 32'd0);
    chk("rst_mid_resp", 32'(rr_if.cli_resp_valid), 32'd0);
    chk("rst_mid_cmd_valid", 32'(rr_if.sdram_cmd_valid), 32'd0);
    chk("rst_mid_rd", 32'(rr_if.sdram_rd), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    rr_if.sdram_rdy = 1'b0;
    rr_if.sdram_resp_valid = 1'b0;
    #1;
    chk("post_rst_tie", 32'(rr_if.cli_cmd_ready), 32'h1);
    exp_q.push_back(0);
    wait_grant(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
